bnn_sequencer: RTL and testbench

Top-level control FSM for the binary MNIST classifier. It loads a 28×28 binary image over an 8-bit valid/ready stream and drives the 3-bit `state` bus that the layer engines decode. It steps layer 1 → layer 2 → layer 3 on each engine's `done`, and latches the final class. A per-layer watchdog returns the design to idle with an error flag if an engine hangs.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bnn_pixel_loader.sv | 47 ++++
 rtl/bnn_sequencer.sv | 156 +++++++++++++++
 tb/tb_bnn_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary MNIST classifier.
//   bnn_state_t : 3-bit state code broadcast by the sequencer and decoded by
//                 every layer engine.
//   IMG_DIM     : image side length in pixels.
//   IMG_PIXELS  : pixels per image.
//   PIX_BEATS   : 8-pixel input beats per image.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_LAYER_1 = 3'b010,
        ST_LAYER_2 = 3'b011,
        ST_LAYER_3 = 3'b100,
        ST_DONE    = 3'b101
    } bnn_state_t;

    localparam int unsigned IMG_DIM    = 28;
    localparam int unsigned IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int unsigned PIX_BEATS  = IMG_PIXELS / 8;

    // True for the three states in which a layer engine is running.
    function automatic logic is_layer(input logic [2:0] s);
        return (s == ST_LAYER_1) || (s == ST_LAYER_2) || (s == ST_LAYER_3);
    endfunction

endpackage

// File: rtl/bnn_pixel_loader.sv
// Image capture for the sequencer: counts accepted 8-pixel beats and writes
// each beat into the flat image register, pixel bit 8*k+i <= pix_data[i].
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the beat counter (accepted start); image is kept
//   beat_en    : one beat accepted this cycle
//   pix_data   : 8 binary pixels of the current beat
//   pixels     : flat image, bit 28*r+c is row r, column c
//   last_beat  : the counter points at the final beat of the image
module bnn_pixel_loader
    import bnn_pkg::*;
#(
    parameter int unsigned PIX_BEATS = bnn_pkg::PIX_BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  beat_en,
    input  logic [7:0]            pix_data,
    output logic [IMG_PIXELS-1:0] pixels,
    output logic                  last_beat
);

    localparam int unsigned BEAT_W = $clog2(PIX_BEATS + 1);

    logic [BEAT_W-1:0] beat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            pixels   <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_en) begin
            // Decoded write keeps each byte lane a plain enable instead of a
            // wide variable shifter.
            for (int unsigned k = 0; k < PIX_BEATS; k++) begin
                if (beat_cnt == BEAT_W'(k)) begin
                    pixels[8*k +: 8] <= pix_data;
                end
            end
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign last_beat = (beat_cnt == BEAT_W'(PIX_BEATS - 1));

endmodule

// File: rtl/bnn_sequencer.sv
// Top-level control FSM for the binary MNIST classifier. Loads one image over
// a valid/ready byte stream, then steps the three layer engines in turn on
// their done flags and latches the final class. A per-layer watchdog aborts
// back to IDLE with error set if an engine never finishes.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin inference (honoured in IDLE/DONE only)
//   pix_valid/pix_data  : input beat stream, pix_ready is the accept
//   pixels              : captured image
//   state               : broadcast state code for the layer engines
//   layer_rst_n         : one-cycle engine clear at LOAD entry
//   l1/l2/l3_done       : sticky engine completion flags
//   l3_class            : classifier output, valid with l3_done
//   busy                : LOAD or any LAYER state
//   result_valid/result : latched class
//   error               : watchdog abort occurred
module bnn_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned PIX_BEATS      = bnn_pkg::PIX_BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [7:0]            pix_data,
    output logic                  pix_ready,
    output logic [IMG_PIXELS-1:0] pixels,
    output logic [2:0]            state,
    output logic                  layer_rst_n,
    input  logic                  l1_done,
    input  logic                  l2_done,
    input  logic                  l3_done,
    input  logic [3:0]            l3_class,
    output logic                  busy,
    output logic                  result_valid,
    output logic [3:0]            result,
    output logic                  error
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Held as a plain vector so the unused codes 110/111 stay representable
    // and can be recovered from.
    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [15:0] wd_cnt;
    logic        start_acc;
    logic        beat_acc;
    logic        last_beat;
    logic        wd_expire;
    logic        timeout;

    assign beat_acc  = pix_valid & pix_ready;
    assign wd_expire = is_layer(state_q) && (wd_cnt == WD_LAST);

    bnn_pixel_loader #(
        .PIX_BEATS (PIX_BEATS)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_acc),
        .beat_en   (beat_acc),
        .pix_data  (pix_data),
        .pixels    (pixels),
        .last_beat (last_beat)
    );

    // Only the current layer's done flag is looked at; done takes priority
    // over a watchdog expiry in the same cycle.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    start_acc = 1'b1;
                end
            end
            ST_LOAD: begin
                if (beat_acc && last_beat) begin
                    state_d = ST_LAYER_1;
                end
            end
            ST_LAYER_1: begin
                if (l1_done) begin
                    state_d = ST_LAYER_2;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_LAYER_2: begin
                if (l2_done) begin
                    state_d = ST_LAYER_3;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_LAYER_3: begin
                if (l3_done) begin
                    state_d = ST_DONE;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wd_cnt       <= '0;
            pix_ready    <= 1'b0;
            busy         <= 1'b0;
            layer_rst_n  <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            error        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                wd_cnt <= '0;
            end else if (is_layer(state_q)) begin
                wd_cnt <= wd_cnt + 16'd1;
            end

            // Registered outputs are computed from the next state so they
            // line up with the state code they describe.
            pix_ready   <= (state_d == ST_LOAD);
            busy        <= (state_d == ST_LOAD) || is_layer(state_d);
            layer_rst_n <= !start_acc;

            if (start_acc) begin
                result_valid <= 1'b0;
                error        <= 1'b0;
            end
            if ((state_q == ST_LAYER_3) && l3_done) begin
                result       <= l3_class;
                result_valid <= 1'b1;
            end
            if (timeout) begin
                error <= 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_bnn_sequencer.sv
module tb_bnn_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         pix_valid = 1'b0;
    logic [7:0]   pix_data = '0;
    logic         l1_done = 1'b0;
    logic         l2_done = 1'b0;
    logic         l3_done = 1'b0;
    logic [3:0]   l3_class = '0;

    logic         pix_ready;
    logic [783:0] pixels;
    logic [2:0]   state;
    logic         layer_rst_n;
    logic         busy;
    logic         result_valid;
    logic [3:0]   result;
    logic         error;

    logic         w_pix_ready;
    logic [783:0] w_pixels;
    logic [2:0]   w_state;
    logic         w_layer_rst_n;
    logic         w_busy;
    logic         w_result_valid;
    logic [3:0]   w_result;
    logic         w_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bnn_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .pixels       (pixels),
        .state        (state),
        .layer_rst_n  (layer_rst_n),
        .l1_done      (l1_done),
        .l2_done      (l2_done),
        .l3_done      (l3_done),
        .l3_class     (l3_class),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .error        (error)
    );

    // Short-watchdog instance sharing all inputs.
    bnn_sequencer #(
        .TIMEOUT_CYCLES (16)
    ) dut_wd (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (w_pix_ready),
        .pixels       (w_pixels),
        .state        (w_state),
        .layer_rst_n  (w_layer_rst_n),
        .l1_done      (l1_done),
        .l2_done      (l2_done),
        .l3_done      (l3_done),
        .l3_class     (l3_class),
        .busy         (w_busy),
        .result_valid (w_result_valid),
        .result       (w_result),
        .error        (w_error)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] px_byte(input int k);
        return pixels[8*k +: 8];
    endfunction

    function automatic int image_errors(input logic [7:0] base);
        int bad = 0;
        for (int k = 0; k < 98; k++) begin
            if (px_byte(k) !== 8'(base + 8'(k))) bad++;
        end
        return bad;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0; l3_class = '0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Feeds beats base+k; model accepts whenever valid is driven in LOAD.
    task automatic load_image(input bit toggle, input logic [7:0] base,
                              input int max_beats, output int cycles,
                              output int early);
        int acc = 0;
        cycles = 0;
        early  = 0;
        for (int i = 0; i < 400; i++) begin
            pix_valid = toggle ? i[0] : 1'b1;
            pix_data  = base + 8'(acc);
            if (state !== 3'b001) early++;
            tick;
            cycles++;
            if (pix_valid) acc++;
            if (acc >= max_beats) break;
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %b expected 000", state); end
        n_checks++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
        n_checks++; if (pixels !== '0) begin n_fail++; $display("FAIL reset_pixels: got nonzero expected 0"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({result_valid, result, error} !== 6'b0) begin n_fail++; $display("FAIL reset_result: got %b expected 000000", {result_valid, result, error}); end
        n_checks++; if (layer_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_layer_rst_n: got %b expected 0", layer_rst_n); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_load_back_to_back;
        int cyc, early;
        do_reset;
        do_start;
        n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL b2b_load_state: got %b expected 001", state); end
        n_checks++; if ({pix_ready, busy} !== 2'b11) begin n_fail++; $display("FAIL b2b_ready_busy: got %b expected 11", {pix_ready, busy}); end
        n_checks++; if (layer_rst_n !== 1'b0) begin n_fail++; $display("FAIL b2b_layer_rst_low: got %b expected 0", layer_rst_n); end
        load_image(1'b0, 8'h00, 98, cyc, early);
        n_checks++; if (state !== 3'b010 || cyc != 98 || early != 0) begin n_fail++; $display("FAIL b2b_load_len: state %b after %0d cycles (early %0d) expected 010 after 98", state, cyc, early); end
        n_checks++; if (px_byte(0) !== 8'h00 || px_byte(1) !== 8'h01) begin n_fail++; $display("FAIL b2b_first_bytes: got %h %h expected 00 01", px_byte(0), px_byte(1)); end
        n_checks++; if (pixels[783:776] !== 8'h61) begin n_fail++; $display("FAIL b2b_last_byte: got %h expected 61", pixels[783:776]); end
        n_checks++; if ({pix_ready, layer_rst_n, busy} !== 3'b011) begin n_fail++; $display("FAIL b2b_after_load: got %b expected 011", {pix_ready, layer_rst_n, busy}); end
    endtask

    task automatic test_load_toggle;
        int cyc, early, bad;
        do_reset;
        do_start;
        load_image(1'b1, 8'h00, 98, cyc, early);
        n_checks++; if (state !== 3'b010 || cyc != 196 || early != 0) begin n_fail++; $display("FAIL toggle_load_len: state %b after %0d cycles (early %0d) expected 010 after 196", state, cyc, early); end
        bad = image_errors(8'h00);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL toggle_image: got %0d wrong bytes expected 0", bad); end
    endtask

    task automatic test_full_pass;
        int cyc, early;
        do_reset;
        do_start;
        load_image(1'b0, 8'h10, 98, cyc, early);
        repeat (1568) tick;
        n_checks++; if (state !== 3'b010 || busy !== 1'b1) begin n_fail++; $display("FAIL pass_l1_dwell: got state %b busy %b expected 010 1", state, busy); end
        l1_done = 1'b1;
        tick;
        n_checks++; if (state !== 3'b011) begin n_fail++; $display("FAIL pass_to_l2: got %b expected 011", state); end
        repeat (200) tick;
        l2_done = 1'b1;
        tick;
        n_checks++; if (state !== 3'b100) begin n_fail++; $display("FAIL pass_to_l3: got %b expected 100", state); end
        repeat (50) tick;
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL pass_rv_early: got %b expected 0", result_valid); end
        l3_done = 1'b1;
        l3_class = 4'd7;
        tick;
        n_checks++; if (state !== 3'b101) begin n_fail++; $display("FAIL pass_to_done: got %b expected 101", state); end
        n_checks++; if ({result_valid, result, busy, error} !== 7'b1_0111_0_0) begin n_fail++; $display("FAIL pass_result: got rv %b result %0d busy %b err %b expected 1 7 0 0", result_valid, result, busy, error); end
        l3_class = 4'd2;
        tick;
        n_checks++; if (result !== 4'd7) begin n_fail++; $display("FAIL pass_result_hold: got %0d expected 7", result); end
        do_start;
        n_checks++; if (state !== 3'b001 || result_valid !== 1'b0) begin n_fail++; $display("FAIL pass_restart: got state %b rv %b expected 001 0", state, result_valid); end
    endtask

    task automatic test_timeout;
        int cyc, early, bad;
        do_reset;
        do_start;
        load_image(1'b0, 8'h00, 98, cyc, early);
        l1_done = 1'b1;
        tick;
        l1_done = 1'b0;
        n_checks++; if (w_state !== 3'b011) begin n_fail++; $display("FAIL wd_l2_entry: got %b expected 011", w_state); end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (w_state !== 3'b011) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wd_early_abort: got %0d cycles out of LAYER_2 expected 0", bad); end
        tick;
        n_checks++; if ({w_state, w_error, w_busy} !== 5'b000_1_0) begin n_fail++; $display("FAIL wd_abort: got state %b err %b busy %b expected 000 1 0", w_state, w_error, w_busy); end
        n_checks++; if (state !== 3'b011 || error !== 1'b0) begin n_fail++; $display("FAIL wd_long_unaffected: got state %b err %b expected 011 0", state, error); end
        do_start;
        n_checks++; if (w_state !== 3'b001 || w_error !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got state %b err %b expected 001 0", w_state, w_error); end
        n_checks++; if (state !== 3'b011) begin n_fail++; $display("FAIL wd_start_in_layer: got %b expected 011", state); end
    endtask

    task automatic test_ignored_inputs;
        int cyc, early, bad;
        do_reset;
        do_start;
        load_image(1'b0, 8'h00, 98, cyc, early);
        start = 1'b1;
        l2_done = 1'b1;
        tick;
        start = 1'b0;
        tick;
        n_checks++; if (state !== 3'b010) begin n_fail++; $display("FAIL ign_l1_hold: got %b expected 010", state); end
        l2_done = 1'b0;
        l1_done = 1'b1;
        tick;
        l1_done = 1'b0;
        pix_valid = 1'b1;
        pix_data = 8'hFF;
        repeat (5) tick;
        n_checks++; if (state !== 3'b011 || pix_ready !== 1'b0) begin n_fail++; $display("FAIL ign_l2_hold: got state %b ready %b expected 011 0", state, pix_ready); end
        pix_valid = 1'b0;
        bad = image_errors(8'h00);
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ign_pixels_stable: got %0d changed bytes expected 0", bad); end
    endtask

    task automatic test_mid_reset;
        int cyc, early;
        do_reset;
        do_start;
        load_image(1'b0, 8'hA0, 40, cyc, early);
        n_checks++; if (state !== 3'b001) begin n_fail++; $display("FAIL mid_pre_state: got %b expected 001", state); end
        rst_n = 1'b0;
        tick;
        n_checks++; if ({state, pix_ready, busy, layer_rst_n, result_valid, error} !== 8'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b expected 00000000", {state, pix_ready, busy, layer_rst_n, result_valid, error}); end
        n_checks++; if (pixels !== '0) begin n_fail++; $display("FAIL mid_reset_pixels: got nonzero expected 0"); end
        rst_n = 1'b1;
        tick;
        do_start;
        load_image(1'b0, 8'h80, 98, cyc, early);
        n_checks++; if (state !== 3'b010 || cyc != 98) begin n_fail++; $display("FAIL mid_reload_len: got state %b after %0d expected 010 after 98", state, cyc); end
        n_checks++; if (px_byte(0) !== 8'h80 || px_byte(40) !== 8'hA8 || px_byte(97) !== 8'hE1) begin n_fail++; $display("FAIL mid_reload_data: got %h %h %h expected 80 a8 e1", px_byte(0), px_byte(40), px_byte(97)); end
    endtask

    initial begin
        tick;
        test_reset;
        test_load_back_to_back;
        test_load_toggle;
        test_full_pass;
        test_timeout;
        test_ignored_inputs;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
